// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and the Decode->Execute control bundle for the MIPS
// control/hazard block.
package mips_ctrl_pkg;

   localparam int ALU_W = 3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic             regwrite;
      logic             memtoreg;
      logic             memwrite;
      logic [ALU_W-1:0] alucontrol;
      logic             alusrc;
      logic             regdst;
   } ctrlDE_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational stall/flush and forward-select generation for the 5-stage
// pipeline. Register 0 never forwards; stall compares deliberately include it.
module hazard_unit #(
   parameter int REGW = 5
) (
   input  logic            branchD,
   input  logic [REGW-1:0] rsD,
   input  logic [REGW-1:0] rtD,
   input  logic [REGW-1:0] rsE,
   input  logic [REGW-1:0] rtE,
   input  logic [REGW-1:0] writeregE,
   input  logic [REGW-1:0] writeregM,
   input  logic [REGW-1:0] writeregW,
   input  logic            regwriteE,
   input  logic            memtoregE,
   input  logic            regwriteM,
   input  logic            memtoregM,
   input  logic            regwriteW,
   output logic            stallF,
   output logic            stallD,
   output logic            flushE,
   output logic            forwardAD,
   output logic            forwardBD,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE
);

   logic lwstall, branchstall, stall;

   always_comb begin
      forwardAE = 2'b00;
      if (rsE != '0 && rsE == writeregM && regwriteM)      forwardAE = 2'b10;
      else if (rsE != '0 && rsE == writeregW && regwriteW) forwardAE = 2'b01;
      forwardBE = 2'b00;
      if (rtE != '0 && rtE == writeregM && regwriteM)      forwardBE = 2'b10;
      else if (rtE != '0 && rtE == writeregW && regwriteW) forwardBE = 2'b01;
   end

   assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
   assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

   assign lwstall = memtoregE && (rtE == rsD || rtE == rtD);
   // A branch compares in Decode, so it must wait for any producer still in E,
   // or a load still in M whose data is not yet on aluoutM.
   assign branchstall = branchD &&
      ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
       (memtoregM && (writeregM == rsD || writeregM == rtD)));

   assign stall  = lwstall || branchstall;
   assign stallF = stall;
   assign stallD = stall;
   assign flushE = stall;

endmodule

// File: rtl/control_hazard_pipe.sv
// Main decoder, ALU decoder and E/M/W control pipeline registers for the
// pipelined MIPS datapath, with branch resolution and the hazard unit.
module control_hazard_pipe
   import mips_ctrl_pkg::*;
#(
   parameter int REGW  = 5,
   parameter int ALUCW = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             equalD,
   input  logic [REGW-1:0]  rsD,
   input  logic [REGW-1:0]  rtD,
   input  logic [REGW-1:0]  rsE,
   input  logic [REGW-1:0]  rtE,
   input  logic [REGW-1:0]  writeregE,
   input  logic [REGW-1:0]  writeregM,
   input  logic [REGW-1:0]  writeregW,
   output logic             pcsrcD,
   output logic             regdstE,
   output logic             alusrcE,
   output logic [ALUCW-1:0] alucontrolE,
   output logic             memwriteM,
   output logic             memtoregW,
   output logic             regwriteW,
   output logic             stallF,
   output logic             stallD,
   output logic             flushE,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE
);

   ctrlDE_t ctrlD, ctrlE;
   logic    branchD;
   logic    regwriteM, memtoregM;

   always_comb begin
      ctrlD   = '0;
      branchD = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctrlD.regwrite = 1'b1;
            ctrlD.regdst   = 1'b1;
            case (funct)
               FN_ADD:  ctrlD.alucontrol = ALU_ADD;
               FN_SUB:  ctrlD.alucontrol = ALU_SUB;
               FN_AND:  ctrlD.alucontrol = ALU_AND;
               FN_OR:   ctrlD.alucontrol = ALU_OR;
               FN_SLT:  ctrlD.alucontrol = ALU_SLT;
               default: begin
                  // Unknown funct still runs an add but must never commit.
                  ctrlD.alucontrol = ALU_ADD;
                  ctrlD.regwrite   = 1'b0;
               end
            endcase
         end
         OP_LW: begin
            ctrlD.regwrite   = 1'b1;
            ctrlD.alusrc     = 1'b1;
            ctrlD.memtoreg   = 1'b1;
            ctrlD.alucontrol = ALU_ADD;
         end
         OP_SW: begin
            ctrlD.memwrite   = 1'b1;
            ctrlD.alusrc     = 1'b1;
            ctrlD.alucontrol = ALU_ADD;
         end
         OP_BEQ: begin
            branchD          = 1'b1;
            ctrlD.alucontrol = ALU_SUB;
         end
         OP_ADDI: begin
            ctrlD.regwrite   = 1'b1;
            ctrlD.alusrc     = 1'b1;
            ctrlD.alucontrol = ALU_ADD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flushE) ctrlE <= '0;
      else                 ctrlE <= ctrlD;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regwriteM <= 1'b0;
         memtoregM <= 1'b0;
         memwriteM <= 1'b0;
         regwriteW <= 1'b0;
         memtoregW <= 1'b0;
      end else begin
         regwriteM <= ctrlE.regwrite;
         memtoregM <= ctrlE.memtoreg;
         memwriteM <= ctrlE.memwrite;
         regwriteW <= regwriteM;
         memtoregW <= memtoregM;
      end
   end

   assign regdstE     = ctrlE.regdst;
   assign alusrcE     = ctrlE.alusrc;
   assign alucontrolE = ALUCW'(ctrlE.alucontrol);
   assign pcsrcD      = branchD & equalD & ~stallD;

   hazard_unit #(.REGW(REGW)) uHazard (
      .branchD   (branchD),
      .rsD       (rsD),
      .rtD       (rtD),
      .rsE       (rsE),
      .rtE       (rtE),
      .writeregE (writeregE),
      .writeregM (writeregM),
      .writeregW (writeregW),
      .regwriteE (ctrlE.regwrite),
      .memtoregE (ctrlE.memtoreg),
      .regwriteM (regwriteM),
      .memtoregM (memtoregM),
      .regwriteW (regwriteW),
      .stallF    (stallF),
      .stallD    (stallD),
      .flushE    (flushE),
      .forwardAD (forwardAD),
      .forwardBD (forwardBD),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE)
   );

endmodule

// File: tb/tb_control_hazard_pipe.sv
// Directed bench: drives instruction sequences through a tiny datapath
// register-address model and checks control/hazard outputs against hand values.
module tb_control_hazard_pipe;
   import mips_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       equalD;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic [4:0] dWr;
   logic       pcsrcD, regdstE, alusrcE, memwriteM, memtoregW, regwriteW;
   logic [2:0] alucontrolE;
   logic       stallF, stallD, flushE, forwardAD, forwardBD;
   logic [1:0] forwardAE, forwardBE;

   int nAsrt = 0;
   int nFail = 0;

   localparam logic [5:0] OP_NOP = 6'b111111;

   control_hazard_pipe #(.REGW(5), .ALUCW(3)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .equalD(equalD),
      .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
      .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
      .pcsrcD(pcsrcD), .regdstE(regdstE), .alusrcE(alusrcE),
      .alucontrolE(alucontrolE), .memwriteM(memwriteM),
      .memtoregW(memtoregW), .regwriteW(regwriteW),
      .stallF(stallF), .stallD(stallD), .flushE(flushE),
      .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nAsrt++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setD(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] w, input logic e);
      op = o; funct = f; rsD = s; rtD = t; dWr = w; equalD = e;
      #1;
   endtask

   // One clock of the datapath address registers; a stall bubbles E and holds D.
   task automatic cyc(input bit stl);
      @(posedge clk);
      #1;
      writeregW = writeregM;
      writeregM = writeregE;
      if (stl) begin
         rsE = '0; rtE = '0; writeregE = '0;
      end else begin
         rsE = rsD; rtE = rtD; writeregE = dWr;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic drain();
      setD(OP_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      repeat (3) cyc(0);
   endtask

   initial begin
      reset = 1'b1;
      rsE = '0; rtE = '0; writeregE = '0; writeregM = '0; writeregW = '0;
      // reset held with a lw in Decode
      setD(OP_LW, 6'd0, 5'd0, 5'd2, 5'd2, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_regwriteW", regwriteW, 0);
      chk("rst_memwriteM", memwriteM, 0);
      chk("rst_memtoregW", memtoregW, 0);
      chk("rst_alusrcE", alusrcE, 0);
      cyc(0);
      chk("lw_alusrcE", alusrcE, 1);
      chk("lw_alucE", alucontrolE, 3'b010);
      chk("lw_regdstE", regdstE, 0);
      chk("postrst_regwriteW", regwriteW, 0);
      chk("postrst_memwriteM", memwriteM, 0);
      setD(OP_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc(0);
      chk("lwM_memwriteM", memwriteM, 0);
      chk("lwM_regwriteW", regwriteW, 0);
      cyc(0);
      chk("lwW_regwriteW", regwriteW, 1);
      chk("lwW_memtoregW", memtoregW, 1);
      cyc(0);
      chk("lwgone_regwriteW", regwriteW, 0);
      drain();

      // Execute forwarding: M distance, W distance, r0 never forwards
      setD(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
      cyc(0);
      setD(OP_RTYPE, FN_ADD, 5'd3, 5'd5, 5'd4, 1'b0);
      cyc(0);
      chk("fwdM_AE", forwardAE, 2'b10);
      chk("fwdM_BE", forwardBE, 2'b00);
      chk("add_regdstE", regdstE, 1);
      setD(OP_RTYPE, FN_AND, 5'd3, 5'd4, 5'd8, 1'b0);
      cyc(0);
      chk("fwdW_AE", forwardAE, 2'b01);
      chk("fwdW_BE", forwardBE, 2'b10);
      chk("and_alucE", alucontrolE, 3'b000);
      setD(OP_RTYPE, FN_ADD, 5'd1, 5'd1, 5'd0, 1'b0);
      cyc(0);
      setD(OP_RTYPE, FN_ADD, 5'd0, 5'd0, 5'd9, 1'b0);
      cyc(0);
      chk("fwdR0_AE", forwardAE, 2'b00);
      chk("fwdR0_BE", forwardBE, 2'b00);
      drain();

      // load-use stall
      setD(OP_LW, 6'd0, 5'd0, 5'd2, 5'd2, 1'b0);
      cyc(0);
      setD(OP_RTYPE, FN_ADD, 5'd2, 5'd7, 5'd6, 1'b0);
      chk("lu_stallF", stallF, 1);
      chk("lu_stallD", stallD, 1);
      chk("lu_flushE", flushE, 1);
      cyc(1);
      chk("lu_stall_clear", stallD, 0);
      chk("lu_bub_alusrcE", alusrcE, 0);
      chk("lu_bub_regdstE", regdstE, 0);
      chk("lu_bub_alucE", alucontrolE, 3'b000);
      cyc(0);
      chk("lu_fwd_AE", forwardAE, 2'b01);
      chk("lu_fwd_BE", forwardBE, 2'b00);
      chk("lu_memtoregW", memtoregW, 1);
      drain();

      // ALU result feeding a branch
      setD(OP_RTYPE, FN_ADD, 5'd2, 5'd3, 5'd1, 1'b0);
      cyc(0);
      setD(OP_BEQ, 6'd0, 5'd1, 5'd0, 5'd0, 1'b1);
      chk("bs_stallD", stallD, 1);
      chk("bs_flushE", flushE, 1);
      chk("bs_pcsrcD", pcsrcD, 0);
      cyc(1);
      chk("bs_stall_clear", stallD, 0);
      chk("bs_fwdAD", forwardAD, 1);
      chk("bs_fwdBD", forwardBD, 0);
      chk("bs_taken", pcsrcD, 1);
      drain();

      // load feeding a branch: two stall cycles
      setD(OP_LW, 6'd0, 5'd0, 5'd1, 5'd1, 1'b0);
      cyc(0);
      setD(OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0, 1'b1);
      chk("lb_stall1", stallD, 1);
      chk("lb_pcsrc1", pcsrcD, 0);
      cyc(1);
      chk("lb_stall2", stallD, 1);
      chk("lb_pcsrc2", pcsrcD, 0);
      cyc(1);
      chk("lb_stall3", stallD, 0);
      chk("lb_taken", pcsrcD, 1);
      chk("lb_fwdAD", forwardAD, 0);
      drain();

      // sw then undefined opcode
      setD(OP_SW, 6'd0, 5'd0, 5'd5, 5'd5, 1'b0);
      cyc(0);
      chk("sw_alusrcE", alusrcE, 1);
      chk("sw_alucE", alucontrolE, 3'b010);
      chk("sw_regdstE", regdstE, 0);
      setD(OP_NOP, FN_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc(0);
      chk("sw_memwriteM", memwriteM, 1);
      chk("ud_alusrcE", alusrcE, 0);
      chk("ud_alucE", alucontrolE, 3'b000);
      chk("ud_regdstE", regdstE, 0);
      cyc(0);
      chk("sw_regwriteW", regwriteW, 0);
      chk("ud_memwriteM", memwriteM, 0);
      cyc(0);
      chk("ud_regwriteW", regwriteW, 0);
      chk("ud_memtoregW", memtoregW, 0);
      drain();

      // unknown funct never commits; slt does
      setD(OP_RTYPE, 6'b111111, 5'd0, 5'd0, 5'd9, 1'b0);
      cyc(0);
      chk("uf_alucE", alucontrolE, 3'b010);
      chk("uf_regdstE", regdstE, 1);
      setD(OP_RTYPE, FN_SLT, 5'd0, 5'd0, 5'd10, 1'b0);
      cyc(0);
      chk("slt_alucE", alucontrolE, 3'b111);
      setD(OP_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc(0);
      chk("uf_regwriteW", regwriteW, 0);
      cyc(0);
      chk("slt_regwriteW", regwriteW, 1);
      drain();

      // mid-flight reset discards an addi in M
      setD(OP_ADDI, 6'd0, 5'd0, 5'd4, 5'd4, 1'b0);
      cyc(0);
      chk("addi_alusrcE", alusrcE, 1);
      setD(OP_NOP, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
      cyc(0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_regwriteW", regwriteW, 0);
      cyc(0);
      chk("midrst_regwriteW2", regwriteW, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsrt, nFail);
      $finish;
   end

endmodule
